alu_controller: RTL and testbench
=================================

ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data path width in bits; all values below assume 16.
REQ-002 The block SHALL have parameter OPW, default 9, meaning width of the one-hot operation select.
REQ-003 The block SHALL have port clock, input, 1 bit: single system clock, rising-edge active.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port a, input, 16 bits: operand A (e.g. program counter).
REQ-006 The block SHALL have port b, input, 16 bits: operand B (e.g. constant 1 for PC increment).
REQ-007 The block SHALL have port result, output, 16 bits: combinational operation result.
REQ-008 The block SHALL have port op, input, 9 bits: one-hot operation select.
REQ-009 The block SHALL have port flags, output, 5 bits: registered status {err, ovf, neg, zero, carry} = bits [4:0].

Function
REQ-010 The block SHALL decode op as one-hot:
- bit0 AND
- bit1 OR
- bit2 XOR
- bit3 ADD (a+b)
- bit4 SUB (a-b)
- bit5 NOT a
- bit6 SHL (a << b[3:0])
- bit7 SHR logical (a >> b[3:0])
- bit8 PASS b
REQ-011 result SHALL be purely combinational from a, b and op, with zero-cycle latency, so a caller can sample it on the same clock edge.
REQ-012 ADD and SUB SHALL wrap modulo 2^16; the result SHALL be the low 16 bits.
REQ-013 The next carry value SHALL be:
- ADD: carry-out of bit 15
- SUB: borrow, i.e. 1 when a < b unsigned
- SHL: last bit shifted out of bit 15
- SHR: last bit shifted out of bit 0
- shift amount 0: 0
- all other operations: 0
REQ-014 The next ovf value SHALL be the signed two's-complement overflow for ADD and SUB, and 0 for all other operations.
REQ-015 The next zero value SHALL be 1 when result == 0x0000; the next neg value SHALL equal result[15].
REQ-016 If op is not exactly one-hot (zero bits or two or more bits set), result SHALL be 0x0000 and the next err value SHALL be 1; otherwise next err SHALL be 0.
REQ-017 For an illegal op, next carry and ovf SHALL be 0, next zero 1 and next neg 0, consistent with result 0x0000.
REQ-018 flags SHALL load all five next values on every rising clock edge while reset_n is high, reflecting the op, a and b present just before that edge; flags SHALL have a latency of one cycle.
REQ-019 There SHALL be no enable or handshake; every cycle is a new operation.

Reset
REQ-020 While reset_n is low, flags SHALL be 5'b00000 immediately, without waiting for a clock edge.
REQ-021 result SHALL remain combinational and SHALL NOT be affected by reset_n.
REQ-022 On reset_n deassertion, flags SHALL first update on the next rising clock edge.
REQ-023 Assertion of reset_n mid-operation SHALL clear flags immediately; the pending update SHALL be discarded.

Verification
REQ-024 PC increment: a=0x0000, b=0x0001, op=0x008 -> result=0x0001 immediately; after the edge, flags=5'b00000.
REQ-025 Wrap-around: a=0xFFFF, b=0x0001, op=0x008 -> result=0x0000; after the edge, carry=1, zero=1, ovf=0, neg=0.
REQ-026 Signed overflow and borrow:
- a=0x7FFF, b=0x0001, ADD -> result=0x8000, ovf=1, neg=1
- a=0x0005, b=0x0007, op=0x010 (SUB) -> result=0xFFFE, carry=1, neg=1
REQ-027 Shifts and logic:
- a=0x8001, b=0x0001, op=0x040 (SHL) -> result=0x0002, carry=1
- a=0x00F0, b=0x0F0F, op=0x004 (XOR) -> result=0x0FFF
REQ-028 Illegal op: op=0x018 or op=0x000 -> result=0x0000; after the edge, err=1, zero=1.
REQ-029 Reset mid-operation: with flags=5'b00011, assert reset_n low between edges -> flags=5'b00000 with no clock edge; result still tracks a, b and op.

Source files
------------

// File: rtl/alu_controller.sv
// One-hot controlled ALU: combinational result path plus a registered
// five-bit status word {err, ovf, neg, zero, carry}.
module alu_controller #(
    parameter int WIDTH = 16,
    parameter int OPW   = 9
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_AND  = {{(OPW-1){1'b0}}, 1'b1};
    localparam logic [OPW-1:0] OP_OR   = OP_AND << 1;
    localparam logic [OPW-1:0] OP_XOR  = OP_AND << 2;
    localparam logic [OPW-1:0] OP_ADD  = OP_AND << 3;
    localparam logic [OPW-1:0] OP_SUB  = OP_AND << 4;
    localparam logic [OPW-1:0] OP_NOT  = OP_AND << 5;
    localparam logic [OPW-1:0] OP_SHL  = OP_AND << 6;
    localparam logic [OPW-1:0] OP_SHR  = OP_AND << 7;
    localparam logic [OPW-1:0] OP_PASS = OP_AND << 8;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   shl_ext_s;
    logic [WIDTH:0]   shr_ext_s;
    logic [SHW-1:0]   shamt_s;

    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             ovf_s;
    logic             err_s;
    logic [4:0]       flags_d;
    logic [4:0]       flags_q;

    // Arithmetic and shift datapaths; the extra bit carries carry/borrow or the last bit shifted out.
    always_comb begin
        shamt_s   = b[SHW-1:0];
        sum_s     = {1'b0, a} + {1'b0, b};
        diff_s    = {1'b0, a} - {1'b0, b};
        shl_ext_s = {1'b0, a} << shamt_s;
        shr_ext_s = {a, 1'b0} >> shamt_s;
    end

    // Operation decode; anything that is not exactly one-hot lands in default as an error.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        err_s    = 1'b0;
        case (op)
            OP_AND:  result_s = a & b;
            OP_OR:   result_s = a | b;
            OP_XOR:  result_s = a ^ b;
            OP_ADD: begin
                result_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result_s = diff_s[WIDTH-1:0];
                carry_s  = diff_s[WIDTH];
                ovf_s    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  result_s = ~a;
            OP_SHL: begin
                result_s = shl_ext_s[WIDTH-1:0];
                carry_s  = shl_ext_s[WIDTH];
            end
            OP_SHR: begin
                result_s = shr_ext_s[WIDTH:1];
                carry_s  = shr_ext_s[0];
            end
            OP_PASS: result_s = b;
            default: begin
                result_s = {WIDTH{1'b0}};
                err_s    = 1'b1;
            end
        endcase
    end

    // Next status word, packed as {err, ovf, neg, zero, carry}.
    always_comb begin
        flags_d = {err_s, ovf_s, result_s[WIDTH-1], (result_s == {WIDTH{1'b0}}), carry_s};
    end

    // Status register; reset clears it immediately and drops any pending update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 5'b00000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign result = result_s;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_controller.sv
// Directed-vector bench for alu_controller: checks the combinational result
// and the one-cycle-later status flags, plus asynchronous reset behaviour.
module tb_alu_controller;

    logic        clock;
    logic        reset_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [8:0]  op;
    logic [15:0] result;
    logic [4:0]  flags;

    int check_cnt;
    int error_cnt;

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] b;
        logic [8:0]  op;
        logic [15:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[$];

    alu_controller #(.WIDTH(16), .OPW(9)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .op      (op),
        .result  (result),
        .flags   (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        check_cnt = check_cnt + 1;
        if (got !== exp) begin
            error_cnt = error_cnt + 1;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        reset_n   = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        op        = 9'h000;

        // flags = {err, ovf, neg, zero, carry}
        vecs.push_back('{"pc_inc",    16'h0000, 16'h0001, 9'h008, 16'h0001, 5'b00000});
        vecs.push_back('{"add_wrap",  16'hFFFF, 16'h0001, 9'h008, 16'h0000, 5'b00011});
        vecs.push_back('{"add_ovf",   16'h7FFF, 16'h0001, 9'h008, 16'h8000, 5'b01100});
        vecs.push_back('{"sub_borrow",16'h0005, 16'h0007, 9'h010, 16'hFFFE, 5'b00101});
        vecs.push_back('{"shl_1",     16'h8001, 16'h0001, 9'h040, 16'h0002, 5'b00001});
        vecs.push_back('{"xor",       16'h00F0, 16'h0F0F, 9'h004, 16'h0FFF, 5'b00000});
        vecs.push_back('{"ill_two",   16'h1234, 16'h5678, 9'h018, 16'h0000, 5'b10010});
        vecs.push_back('{"ill_zero",  16'h1234, 16'h5678, 9'h000, 16'h0000, 5'b10010});
        vecs.push_back('{"and",       16'hF0F0, 16'h0FF0, 9'h001, 16'h00F0, 5'b00000});
        vecs.push_back('{"or",        16'hF000, 16'h000F, 9'h002, 16'hF00F, 5'b00100});
        vecs.push_back('{"not",       16'h00FF, 16'h1111, 9'h020, 16'hFF00, 5'b00100});
        vecs.push_back('{"shr_2",     16'h0003, 16'h0002, 9'h080, 16'h0000, 5'b00011});
        vecs.push_back('{"shl_0",     16'h8000, 16'h0010, 9'h040, 16'h8000, 5'b00100});
        vecs.push_back('{"shr_0",     16'h0001, 16'h0020, 9'h080, 16'h0001, 5'b00000});
        vecs.push_back('{"pass_b",    16'h1234, 16'h0000, 9'h100, 16'h0000, 5'b00010});
        vecs.push_back('{"sub_eq",    16'h1234, 16'h1234, 9'h010, 16'h0000, 5'b00010});
        vecs.push_back('{"sub_ovf",   16'h8000, 16'h0001, 9'h010, 16'h7FFF, 5'b01000});
        vecs.push_back('{"shl_15",    16'h0002, 16'h000F, 9'h040, 16'h0000, 5'b00011});
        vecs.push_back('{"ill_high",  16'h0001, 16'h0001, 9'h101, 16'h0000, 5'b10010});

        // Reset state: flags clear while reset is held, across an edge too.
        #2;
        check_val("rst_flags", {11'd0, flags}, 16'h0000);
        a  = 16'hFFFF;
        b  = 16'h0001;
        op = 9'h008;
        @(posedge clock);
        #1;
        check_val("rst_hold_flags", {11'd0, flags}, 16'h0000);
        check_val("rst_result_live", result, 16'h0000);

        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            a  = vecs[i].a;
            b  = vecs[i].b;
            op = vecs[i].op;
            #1;
            check_val({vecs[i].tag, "_res"}, result, vecs[i].res);
            @(posedge clock);
            #1;
            check_val({vecs[i].tag, "_flg"}, {11'd0, flags}, {11'd0, vecs[i].flg});
            @(negedge clock);
        end

        // Mid-operation reset: load carry+zero, then reset between edges.
        a  = 16'hFFFF;
        b  = 16'h0001;
        op = 9'h008;
        @(posedge clock);
        #1;
        check_val("pre_rst_flags", {11'd0, flags}, 16'h0003);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_flags", {11'd0, flags}, 16'h0000);
        a  = 16'h0002;
        b  = 16'h0003;
        #1;
        check_val("mid_rst_result", result, 16'h0005);
        @(posedge clock);
        #1;
        check_val("rst_edge_discard", {11'd0, flags}, 16'h0000);

        // Release reset; flags hold zero until the next rising edge.
        @(negedge clock);
        reset_n = 1'b1;
        op      = 9'h000;
        #1;
        check_val("post_rst_wait", {11'd0, flags}, 16'h0000);
        @(posedge clock);
        #1;
        check_val("post_rst_first", {11'd0, flags}, 16'h0012);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
